// File: rtl/dpram_stream_reader.sv
// Block reader for the simple_dpram read port: fetches length words starting at
// base_addr and streams them in address order through a credit-limited skid FIFO.
module dpram_stream_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid/out_data/out_last never depend on out_ready.

    localparam int DEPTH = RD_LATENCY + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W:0]         len_q;
    logic [ADDR_W:0]         issued_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [RD_LATENCY-1:0]   pipe_vld;
    logic [RD_LATENCY-1:0]   pipe_last;
    logic [DATA_W-1:0]       mem_data [DEPTH];
    logic                    mem_last [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        inflight;
    logic                    credit_ok;
    logic                    issue;
    logic                    issue_last;
    logic                    push;
    logic                    pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld[i]);
        end
    end

    // Every issued read already owns a FIFO slot, so the buffer cannot overflow.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
    assign issue      = (state == S_RUN) && (issued_q < len_q) && credit_ok;
    assign issue_last = (issued_q == (len_q - (ADDR_W + 1)'(1)));
    assign push       = pipe_vld[RD_LATENCY-1];
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        ram_rd_en   = issue;
        ram_rd_addr = addr_q;
        out_valid   = (count != '0);
        out_data    = '0;
        out_last    = 1'b0;
        dbg_state   = state;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_last = mem_last[rd_ptr];
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            issued_q <= '0;
            addr_q   <= '0;
        end else if (state == S_IDLE && start && length != '0) begin
            len_q    <= length;
            issued_q <= '0;
            addr_q   <= base_addr;
        end else if (issue) begin
            issued_q <= issued_q + (ADDR_W + 1)'(1);
            addr_q   <= addr_q + ADDR_W'(1);
        end
    end

    // Issue strobes ride alongside the RAM pipeline; the tail marks valid read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld[0]  <= issue;
            pipe_last[0] <= issue && issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= ram_rd_data;
            mem_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: behavioural RAM, per-block observation, and a
// reference model built from address arithmetic over the RAM contents.
module tb_dpram_stream_reader;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LAT   = 1;
    localparam int DEPTH = LAT + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    dbg_state;

    dpram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM (garbage when no read is pending) ----------------
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_rd_en ? ram[ram_rd_addr] : DW'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[LAT-1];

    logic [AW+DW+4:0] snap;
    assign snap = {busy, done, ram_rd_en, ram_rd_addr, out_valid, out_data, out_last};

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_q [$];
    logic          exp_last [$];

    function automatic void build_expect(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        exp_addr.delete(); exp_q.delete(); exp_last.delete();
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_q.push_back(ram[a]);
            exp_last.push_back(i == len - 1);
        end
    endfunction

    // ---------------- observations of one block ----------------
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            got_hs_cyc [$];
    int done_cyc, done_cnt, busy_at_done, first_valid, stab_err, max_out, busy_seen;

    // Called at a negedge; start is presented in that cycle (cycle 0).
    // mode 0: ready=1, 1: random ready, 2: ready low for cycles [stall_from, stall_to)
    task automatic run_block(input logic [AW-1:0] base, input int len, input int mode,
                             input int stall_from, input int stall_to, input int inject_c,
                             input int abort_hs, input int max_cyc);
        int issued, accepted;
        logic pv, pl;
        logic [DW-1:0] pd;
        got_addr.delete(); got_data.delete(); got_last.delete(); got_hs_cyc.delete();
        done_cyc = -1; done_cnt = 0; busy_at_done = 0; first_valid = -1;
        stab_err = 0; max_out = 0; busy_seen = 0; issued = 0; accepted = 0; pv = 1'b0;
        pl = 1'b0; pd = '0;
        start = 1'b1; base_addr = base; length = (AW+1)'(len);
        @(negedge clk);
        base_addr = AW'($urandom);
        length = (AW+1)'($urandom_range(0, 256));
        for (int c = 1; c <= max_cyc; c++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(c >= stall_from && c < stall_to);
            endcase
            if (c == inject_c) begin
                start = 1'b1; base_addr = AW'($urandom); length = (AW+1)'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            #1;
            if (ram_rd_en) begin got_addr.push_back(ram_rd_addr); issued++; end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (busy) busy_seen = 1;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (pv && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) stab_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(busy); end
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_last.push_back(out_last);
                got_hs_cyc.push_back(c); accepted++;
            end
            pv = out_valid && !out_ready; pd = out_data; pl = out_last;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
            if (abort_hs > 0 && accepted >= abort_hs) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if (snap !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h expected 0", snap); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (snap !== '0) begin
                n_fail++; $display("FAIL idle_outputs: cycle %0d got %0h expected 0", i, snap);
            end
        end
    endtask

    task automatic test_directed;
        for (int i = 0; i < 4; i++) ram[8'h10 + i] = 32'hA0 + DW'(i);
        build_expect(8'h10, 4);
        run_block(8'h10, 4, 0, 0, 0, 0, 0, 40);
        n_cmp++;
        if (got_data.size() != 4) begin
            n_fail++; $display("FAIL dir_count: got %0d expected 4", got_data.size());
        end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last[i] || got_hs_cyc[i] != 3 + i) begin
                n_fail++;
                $display("FAIL dir_word%0d: got %0h/last %0b/cyc %0d expected %0h/last %0b/cyc %0d",
                         i, got_data[i], got_last[i], got_hs_cyc[i], exp_q[i], exp_last[i], 3 + i);
            end
        end
        n_cmp++;
        if (first_valid != 2 + LAT) begin
            n_fail++; $display("FAIL dir_first_valid: got %0d expected %0d", first_valid, 2 + LAT);
        end
        n_cmp++;
        if (done_cyc != 7 || done_cnt != 1 || busy_at_done != 0) begin
            n_fail++;
            $display("FAIL dir_done: got cyc %0d cnt %0d busy %0d expected cyc 7 cnt 1 busy 0",
                     done_cyc, done_cnt, busy_at_done);
        end
        n_cmp++;
        if (got_addr.size() != 4 || got_addr[0] !== 8'h10) begin
            n_fail++; $display("FAIL dir_addr: got %0d reads first %0h expected 4 reads first 10",
                               got_addr.size(), got_addr[0]);
        end
    endtask

    task automatic test_wrap;
        build_expect(8'hFE, 4);
        run_block(8'hFE, 4, 1, 0, 0, 0, 0, 100);
        n_cmp++;
        if (got_addr.size() != 4) begin
            n_fail++; $display("FAIL wrap_reads: got %0d expected 4", got_addr.size());
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_addr[i] !== exp_addr[i]) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %0h expected %0h", i, got_addr[i], exp_addr[i]);
            end
        end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL wrap_data%0d: got %0h expected %0h", i, got_data[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stab_err != 0 || max_out > DEPTH || done_cnt != 1) begin
            n_fail++; $display("FAIL wrap_rules: got stab %0d out %0d done %0d expected 0 <=%0d 1",
                               stab_err, max_out, done_cnt, DEPTH);
        end
    endtask

    task automatic test_stall;
        logic [AW-1:0] b;
        b = AW'($urandom);
        build_expect(b, 12);
        run_block(b, 12, 2, 5, 25, 0, 0, 120);
        n_cmp++;
        if (max_out != DEPTH) begin
            n_fail++; $display("FAIL stall_credit: got %0d outstanding expected %0d", max_out, DEPTH);
        end
        n_cmp++;
        if (got_data.size() != 12 || got_addr.size() != 12) begin
            n_fail++; $display("FAIL stall_count: got %0d words %0d reads expected 12 12",
                               got_data.size(), got_addr.size());
        end
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL stall_data%0d: got %0h expected %0h", i, got_data[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stab_err != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL stall_rules: got stab %0d done %0d expected 0 1", stab_err, done_cnt);
        end
    endtask

    task automatic test_zero_length;
        run_block(AW'($urandom), 0, 0, 0, 0, 0, 0, 20);
        n_cmp++;
        if (done_cyc != 1 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_done: got cyc %0d cnt %0d expected 1 1", done_cyc, done_cnt);
        end
        n_cmp++;
        if (got_addr.size() != 0 || busy_seen != 0 || got_data.size() != 0) begin
            n_fail++; $display("FAIL zero_quiet: got %0d reads busy %0d words %0d expected 0 0 0",
                               got_addr.size(), busy_seen, got_data.size());
        end
    endtask

    task automatic test_start_ignored;
        logic [AW-1:0] b;
        b = AW'($urandom);
        build_expect(b, 6);
        run_block(b, 6, 0, 0, 0, 3, 0, 40);
        n_cmp++;
        if (got_data.size() != 6 || got_addr.size() != 6 || done_cyc != 2 + LAT + 6) begin
            n_fail++; $display("FAIL ign_shape: got %0d words %0d reads done %0d expected 6 6 %0d",
                               got_data.size(), got_addr.size(), done_cyc, 2 + LAT + 6);
        end
        for (int i = 0; i < 6 && i < got_data.size() && i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_addr[i] !== exp_addr[i]) begin
                n_fail++; $display("FAIL ign_word%0d: got %0h@%0h expected %0h@%0h",
                                   i, got_data[i], got_addr[i], exp_q[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [AW-1:0] b;
        b = AW'($urandom);
        build_expect(b, 8);
        run_block(b, 8, 1, 0, 0, 0, 2, 100);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        n_cmp++;
        if (snap !== '0) begin n_fail++; $display("FAIL midrst_async: got %0h expected 0", snap); end
        n_cmp++;
        if (got_data.size() != 2 || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]) begin
            n_fail++; $display("FAIL midrst_prefix: got %0d words first %0h expected 2 first %0h",
                               got_data.size(), got_data[0], exp_q[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b = AW'($urandom);
        build_expect(b, 2);
        run_block(b, 2, 1, 0, 0, 0, 0, 40);
        n_cmp++;
        if (got_data.size() != 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL midrst_count: got %0d words done %0d expected 2 1",
                               got_data.size(), done_cnt);
        end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL midrst_word%0d: got %0h expected %0h", i, got_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] b;
        int len, mode;
        for (int k = 0; k < 7; k++) begin
            b    = AW'($urandom);
            len  = (k == 6) ? 256 : $urandom_range(1, 40);
            mode = (k == 6) ? 0 : 1;
            build_expect(b, len);
            run_block(b, len, mode, 0, 0, 0, 0, 4 * len + 50);
            n_cmp++;
            if (got_data.size() != len || got_addr.size() != len || done_cnt != 1 || busy_at_done != 0) begin
                n_fail++;
                $display("FAIL b2b%0d_shape: got %0d words %0d reads done %0d busy %0d expected %0d %0d 1 0",
                         k, got_data.size(), got_addr.size(), done_cnt, busy_at_done, len, len);
            end
            n_cmp++;
            if (stab_err != 0 || max_out > DEPTH) begin
                n_fail++; $display("FAIL b2b%0d_rules: got stab %0d out %0d expected 0 <=%0d",
                                   k, stab_err, max_out, DEPTH);
            end
            for (int i = 0; i < len && i < got_data.size() && i < got_addr.size(); i++) begin
                n_cmp++;
                if (got_data[i] !== exp_q[i] || got_last[i] !== exp_last[i] || got_addr[i] !== exp_addr[i]) begin
                    n_fail++; $display("FAIL b2b%0d_word%0d: got %0h@%0h expected %0h@%0h",
                                       k, i, got_data[i], got_addr[i], exp_q[i], exp_addr[i]);
                end
            end
            if (mode == 0) begin
                n_cmp++;
                if (done_cyc != 2 + LAT + len) begin
                    n_fail++; $display("FAIL b2b%0d_done: got %0d expected %0d", k, done_cyc, 2 + LAT + len);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
        test_reset();
        @(negedge clk);
        test_directed();
        test_wrap();
        test_stall();
        test_zero_length();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side engine for the `simple_dpram` read port. On a start command it fetches a contiguous block of words from the RAM and presents them in order on a valid/ready output stream. It hides the RAM's fixed read latency behind a small credit-controlled skid buffer. It sits between the dual-port RAM and any downstream consumer, as the counterpart to whatever writes the RAM's other port.

## Interface
- `ADDR_W`, default 8: RAM address width; the RAM holds 2^ADDR_W words.
- `DATA_W`, default 32: RAM and stream data width.
- `RD_LATENCY`, default 1: RAM read latency in cycles, legal values 1..3. Data appears RD_LATENCY cycles after `ram_rd_en` is high.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a block read; sampled only while idle.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `length`  in  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with `start`.
- `busy`  out  1  block in progress.
- `done`  out  1  one-cycle pulse at block completion.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_rd_addr`  out  ADDR_W  RAM read address.
- `ram_rd_data`  in  DATA_W  RAM read data; valid RD_LATENCY cycles after the strobe.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  stream word.
- `out_last`  out  1  marks the final word of the block.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - `start`=1 with `length`>0 captures `base_addr` and `length` and moves to RUN.
  - `start`=1 with `length`=0 moves directly to DONE; no RAM access occurs.
- RUN:
  - One read is issued per cycle while issued < length and (reads in flight + buffer occupancy) < DEPTH, where DEPTH = RD_LATENCY+2.
  - Each issue increments the address modulo 2^ADDR_W. A block from 0xFE with length 4 reads 0xFE, 0xFF, 0x00, 0x01.
  - Returning data is written into the DEPTH-entry FIFO, tagged `last` when it is word `length`-1.
  - RUN moves to DONE on the handshake (`out_valid`&`out_ready`) of the `last` word.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in RUN and DONE.
- In flight tracking: a RD_LATENCY-deep shift register of issue strobes marks when `ram_rd_data` is captured. No other counter may gate data capture.
- Stream rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a handshake.
  - Words leave strictly in address order.
- The credit rule guarantees the FIFO never overflows regardless of `out_ready` behaviour.
- A simultaneous FIFO push and pop on the same cycle is legal at any occupancy, including full and empty.
- Counters are ADDR_W+1 bits wide so `length`=2^ADDR_W (a full-RAM read) completes.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `ram_rd_en`=0, `ram_rd_addr`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - FIFO empty, state IDLE.
- Reset asserted mid-block discards all buffered and in-flight data. Outputs return to reset values asynchronously. Late RAM data arriving after reset release is ignored.
- `start` is sampled at edge E0. All cycle numbers below count from E0.
  - `busy` is high from cycle 1.
  - First `ram_rd_en` is in cycle 1 with `ram_rd_addr`=`base_addr`.
  - `ram_rd_data` is captured at the end of cycle 1+RD_LATENCY.
  - `out_valid` is first high in cycle 2+RD_LATENCY.
- With `out_ready` held at 1, throughput is one word per cycle. The last word is on the stream in cycle 1+RD_LATENCY+length.
- `done` pulses in the cycle after the last handshake. `busy` is 0 in that cycle.
- A new `start` is accepted in the cycle after `done`.
- `length`=0: `busy` stays 0, `done` pulses in cycle 1, `ram_rd_en` never asserts.

## Test plan
- Reset, then idle 5 cycles: every output stays at its reset value and `ram_rd_en` stays 0.
- Preload RAM[0x10..0x13]=0xA0..0xA3. Start base 0x10, length 4, `out_ready`=1, RD_LATENCY=1:
  - stream 0xA0, 0xA1, 0xA2, 0xA3 on cycles 3..6;
  - `out_last` high only on 0xA3;
  - `done` on cycle 7.
- Start base 0xFE, length 4, random `out_ready`:
  - addresses 0xFE, 0xFF, 0x00, 0x01, in order, with no duplicates;
  - data is held stable during stalls;
  - in-flight + buffered never exceeds DEPTH.
- Hold `out_ready`=0 for 20 cycles mid-block, then release: at most DEPTH reads are issued, no word is lost, and the order is preserved.
- Start with length 0: `done` on cycle 1, no RAM reads, `busy` stays 0. Start asserted during RUN is ignored.
- Assert `rst_n`=0 after 2 of 8 words have been handshaken:
  - outputs go to reset values immediately;
  - after release, a new block of length 2 streams correct data with no stale words.
